// File: rtl/dma_axi_wr_master.sv
// DMA engine to AXI4 write master bridge.
// Accepts burst requests from the engine and issues them on AW. A small
// length queue tracks accepted bursts so that W beats flow only for accepted
// bursts and WLAST is generated locally. Open bursts are counted until their
// B response arrives. Any bad response or engine framing mismatch sets a
// sticky error flag.
module dma_axi_wr_master #(
  parameter int MAX_OUTST = 4  // max un-responded bursts, power of 2, 2..8
) (
  input  logic        clk,
  input  logic        rst,
  // engine request channel
  input  logic [31:0] wr_req_addr_i,
  input  logic [4:0]  wr_req_len_i,
  input  logic        wr_req_valid_i,
  output logic        wr_req_ready_o,
  // engine data channel
  input  logic [31:0] wr_data_i,
  input  logic        wr_valid_i,
  input  logic        wr_last_i,
  output logic        wr_ready_o,
  // AXI AW
  output logic [31:0] awaddr_o,
  output logic [7:0]  awlen_o,
  output logic [2:0]  awsize_o,
  output logic [1:0]  awburst_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  // AXI W
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wlast_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  // AXI B
  input  logic [1:0]  bresp_i,
  input  logic        bvalid_i,
  output logic        bready_o,
  // status
  output logic        busy_o,
  output logic [3:0]  outstanding_o,
  output logic        err_o,
  input  logic        err_clr_i
);

  localparam int PW = $clog2(MAX_OUTST);
  localparam int CW = PW + 1;

  // AW channel state
  logic [31:0] awaddr_q, awaddr_d;
  logic [7:0]  awlen_q, awlen_d;
  logic        awvalid_q, awvalid_d;

  // burst bookkeeping
  logic [3:0]  outstanding_q, outstanding_d;
  logic        err_q, err_d;
  logic [4:0]  bcnt_q, bcnt_d;

  // length queue: one entry per accepted burst whose W beats are not done
  logic [4:0]    lenq_mem [MAX_OUTST];
  logic [PW-1:0] lenq_wptr_q, lenq_wptr_d;
  logic [PW-1:0] lenq_rptr_q, lenq_rptr_d;
  logic [PW-1:0] lenq_rptr_nxt;
  logic [CW-1:0] lenq_cnt_q, lenq_cnt_d;
  logic          lenq_empty, lenq_full;

  // handshake and event strobes
  logic req_hs, w_hs, last_hs, b_hs, bcnt_zero;
  logic frame_err, resp_err;
  logic [4:0] head_next;

  // Combinational outputs and handshake decode.
  always_comb begin
    lenq_empty     = (lenq_cnt_q == '0);
    lenq_full      = (lenq_cnt_q == CW'(MAX_OUTST));
    lenq_rptr_nxt  = lenq_rptr_q + 1'b1;

    wr_req_ready_o = !awvalid_q && (outstanding_q < 4'(MAX_OUTST)) && !lenq_full;
    req_hs         = wr_req_valid_i && wr_req_ready_o;

    wdata_o        = wr_data_i;
    wvalid_o       = wr_valid_i && !lenq_empty;
    wr_ready_o     = wready_i && !lenq_empty;
    w_hs           = wvalid_o && wready_i;
    bcnt_zero      = (bcnt_q == 5'd0);
    wlast_o        = wvalid_o && bcnt_zero;
    last_hs        = w_hs && bcnt_zero;

    bready_o       = (outstanding_q != 4'd0);
    b_hs           = bvalid_i && bready_o;

    frame_err      = w_hs && (wr_last_i != bcnt_zero);
    resp_err       = b_hs && (bresp_i != 2'b00);

    awaddr_o       = awaddr_q;
    awlen_o        = awlen_q;
    awvalid_o      = awvalid_q;
    awsize_o       = 3'b010;
    awburst_o      = 2'b01;
    wstrb_o        = 4'hF;
    outstanding_o  = outstanding_q;
    err_o          = err_q;
    busy_o         = awvalid_q || (outstanding_q != 4'd0) || !lenq_empty;
  end

  // Next-state computation for all registered state.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    awaddr_d      = awaddr_q;
    awlen_d       = awlen_q;
    awvalid_d     = awvalid_q;
    outstanding_d = outstanding_q;
    lenq_wptr_d   = lenq_wptr_q;
    lenq_rptr_d   = lenq_rptr_q;
    lenq_cnt_d    = lenq_cnt_q;
    bcnt_d        = bcnt_q;

    // AW: capture on request, hold until the slave accepts
    if (req_hs) begin
      awaddr_d  = wr_req_addr_i;
      awlen_d   = {3'b000, wr_req_len_i};
      awvalid_d = 1'b1;
    end else if (awvalid_q && awready_i) begin
      awvalid_d = 1'b0;
    end

    // open-burst counter; simultaneous open and close cancel out
    unique case ({req_hs, b_hs})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase

    // length queue pointers and occupancy
    if (req_hs)  lenq_wptr_d = lenq_wptr_q + 1'b1;
    if (last_hs) lenq_rptr_d = lenq_rptr_nxt;
    unique case ({req_hs, last_hs})
      2'b10:   lenq_cnt_d = lenq_cnt_q + 1'b1;
      2'b01:   lenq_cnt_d = lenq_cnt_q - 1'b1;
      default: lenq_cnt_d = lenq_cnt_q;
    endcase

    // length of the burst that follows the head: a queued entry, or the one
    // being pushed right now when the head is the only entry
    if (lenq_cnt_q > CW'(1)) head_next = lenq_mem[lenq_rptr_nxt];
    else if (req_hs)         head_next = wr_req_len_i;
    else                     head_next = 5'd0;

    // beat counter always mirrors the remaining beats of the head burst
    if (last_hs)                  bcnt_d = head_next;
    else if (w_hs)                bcnt_d = bcnt_q - 5'd1;
    else if (lenq_empty && req_hs) bcnt_d = wr_req_len_i;

    // sticky error: a new error in the same cycle as a clear wins
    err_d = (err_q && !err_clr_i) || frame_err || resp_err;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      awaddr_q      <= '0;
      awlen_q       <= '0;
      awvalid_q     <= 1'b0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      bcnt_q        <= '0;
      lenq_wptr_q   <= '0;
      lenq_rptr_q   <= '0;
      lenq_cnt_q    <= '0;
    end else begin
      awaddr_q      <= awaddr_d;
      awlen_q       <= awlen_d;
      awvalid_q     <= awvalid_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      bcnt_q        <= bcnt_d;
      lenq_wptr_q   <= lenq_wptr_d;
      lenq_rptr_q   <= lenq_rptr_d;
      lenq_cnt_q    <= lenq_cnt_d;
    end
  end

  // Length queue storage write on each accepted request.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; entries are only read while the occupancy count marks them valid.
    if (req_hs) lenq_mem[lenq_wptr_q] <= wr_req_len_i;
  end

endmodule
